// File: rtl/uio_port_arbiter.sv
// Round-robin owner arbitration of one shared 8-bit uio pad bus among four requesters.
// Define UIO_ARB_TIMEOUT_EN to enable hold-time preemption of a long-running owner.
module uio_port_arbiter #(
   parameter int MAX_HOLD   = 16,
   parameter int TURNAROUND = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [3:0]  req,
   input  logic [31:0] wr_data,
   input  logic [31:0] wr_oe,
   input  logic [7:0]  uio_in,
   output logic [7:0]  uio_out,
   output logic [7:0]  uio_oe,
   output logic [3:0]  grant,
   output logic [7:0]  rd_data,
   output logic        busy
);

   // Level handshake: a requester holds req high until it sees its grant bit,
   // keeps it high for as long as it wants the bus, and drops it to release.
   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;

   state_t     state, state_nxt;
   logic [3:0] grant_nxt;
   logic [1:0] rr_ptr, rr_ptr_nxt;
   logic [2:0] turn_cnt, turn_cnt_nxt;
   logic [1:0] win_idx;
   logic       win_vld;
   logic       start_grant;
   logic       owner_req;
   logic       preempt;
   logic [7:0] out_mux, oe_mux;

   // Lowest offset from rr_ptr wins; the descending loop lets it overwrite last.
   always_comb begin
      win_vld = 1'b0;
      win_idx = rr_ptr;
      for (int k = 3; k >= 0; k--) begin
         if (req[rr_ptr + 2'(k)]) begin
            win_vld = 1'b1;
            win_idx = rr_ptr + 2'(k);
         end
      end
   end

   assign owner_req   = |(req & grant);
   assign start_grant = ena && win_vld;

`ifdef UIO_ARB_TIMEOUT_EN
   logic [7:0] hold_cnt, hold_cnt_nxt;

   // hold_cnt reads k during the k-th GRANT cycle, so MAX_HOLD cycles are served.
   assign preempt = (hold_cnt == 8'(MAX_HOLD)) && |(req & ~grant);

   always_comb begin
      hold_cnt_nxt = '0;
      if (state_nxt == ST_GRANT) begin
         if (state != ST_GRANT)
            hold_cnt_nxt = 8'd1;
         else if (hold_cnt < 8'(MAX_HOLD))
            hold_cnt_nxt = hold_cnt + 8'd1;
         else
            hold_cnt_nxt = hold_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold_cnt <= '0;
      else        hold_cnt <= hold_cnt_nxt;
   end
`else
   // No preemption in this build; MAX_HOLD only has meaning with the timeout enabled.
   assign preempt = (MAX_HOLD < 0);
`endif

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      rr_ptr_nxt   = rr_ptr;
      turn_cnt_nxt = turn_cnt;
      case (state)
         ST_IDLE: begin
            if (start_grant) begin
               state_nxt  = ST_GRANT;
               grant_nxt  = 4'b0001 << win_idx;
               rr_ptr_nxt = win_idx + 2'd1;
            end
         end
         ST_GRANT: begin
            if (!owner_req || preempt) begin
               state_nxt    = ST_TURN;
               grant_nxt    = '0;
               turn_cnt_nxt = 3'(TURNAROUND - 1);
            end
         end
         ST_TURN: begin
            if (turn_cnt != 3'd0) begin
               turn_cnt_nxt = turn_cnt - 3'd1;
            end else if (start_grant) begin
               state_nxt  = ST_GRANT;
               grant_nxt  = 4'b0001 << win_idx;
               rr_ptr_nxt = win_idx + 2'd1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         turn_cnt <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         rr_ptr   <= rr_ptr_nxt;
         turn_cnt <= turn_cnt_nxt;
      end
   end

   always_comb begin
      out_mux = '0;
      oe_mux  = '0;
      for (int n = 0; n < 4; n++) begin
         if (grant[n]) begin
            out_mux = out_mux | wr_data[8*n +: 8];
            oe_mux  = oe_mux  | wr_oe[8*n +: 8];
         end
      end
   end

   assign uio_out = (state == ST_GRANT) ? out_mux : 8'h00;
   assign uio_oe  = (state == ST_GRANT && ena) ? oe_mux : 8'h00;
   assign rd_data = uio_in;
   assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_uio_port_arbiter.sv
// Bench for uio_port_arbiter: directed scenario tasks plus a randomized run
// checked against an ownership-level reference model.
module tb_uio_port_arbiter;

   localparam int MAX_HOLD   = 16;
   localparam int TURNAROUND = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] wr_oe = '0;
   logic [7:0]  uio_in = '0;
   logic [7:0]  uio_out, uio_oe, rd_data;
   logic [3:0]  grant;
   logic        busy;

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the bus, how many idle cycles remain, who owned it last.
   int m_owner, m_last, m_turn, m_hold;

   uio_port_arbiter #(.MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .wr_data(wr_data),
      .wr_oe(wr_oe), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe),
      .grant(grant), .rd_data(rd_data), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      m_owner = -1;
      m_last  = -1;
      m_turn  = 0;
      m_hold  = 0;
   endfunction

   function automatic void model_try_grant();
      if (ena && req != 4'b0000) begin
         for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_last + 1 + k) % 4;
            if (m_owner < 0 && req[i]) begin
               m_owner = i;
               m_hold  = 1;
            end
         end
      end
   endfunction

   function automatic void model_step();
      if (!rst_n) begin
         model_reset();
      end else if (m_owner >= 0) begin
         bit rel;
         rel = !req[m_owner];
`ifdef UIO_ARB_TIMEOUT_EN
         if (m_hold == MAX_HOLD && (req & ~(4'b0001 << m_owner)) != 4'b0000) rel = 1'b1;
`endif
         if (rel) begin
            m_last  = m_owner;
            m_owner = -1;
            m_turn  = TURNAROUND;
         end else if (m_hold < MAX_HOLD) begin
            m_hold = m_hold + 1;
         end
      end else if (m_turn > 0) begin
         m_turn = m_turn - 1;
         if (m_turn == 0) model_try_grant();
      end else begin
         model_try_grant();
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ena = 1'b0; req = '0; wr_data = '0; wr_oe = '0; uio_in = '0;
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      req = 4'hF; ena = 1'b1; wr_data = '1; wr_oe = '1; uio_in = 8'h3C;
      repeat (2) tick();
      #1;
      total++; if (grant !== 4'h0) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
      total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL reset_uio_out: got %h want 00", uio_out); end
      total++; if (uio_oe !== 8'h00) begin bad++; $display("FAIL reset_uio_oe: got %h want 00", uio_oe); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (rd_data !== 8'h3C) begin bad++; $display("FAIL reset_rd_data: got %h want 3c", rd_data); end
      req = '0;
      rst_n = 1'b1;
      tick();
      total++; if (busy !== 1'b0 || grant !== 4'h0) begin bad++; $display("FAIL idle_no_req: got busy=%b grant=%b want 0/0000", busy, grant); end
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0001; ena = 1'b1;
      wr_data = {24'h123456, 8'hA5}; wr_oe = {24'h00FF00, 8'hFF};
      #1;
      total++; if (grant !== 4'h0) begin bad++; $display("FAIL single_pre_edge: got %b want 0000", grant); end
      tick();
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", grant); end
      total++; if (uio_out !== 8'hA5) begin bad++; $display("FAIL single_uio_out: got %h want a5", uio_out); end
      total++; if (uio_oe !== 8'hFF) begin bad++; $display("FAIL single_uio_oe: got %h want ff", uio_oe); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
      wr_data[7:0] = 8'h5A;
      #1;
      total++; if (uio_out !== 8'h5A) begin bad++; $display("FAIL single_comb_mux: got %h want 5a", uio_out); end
      req = 4'b0000;
      tick();
      total++; if (grant !== 4'h0 || uio_out !== 8'h00 || uio_oe !== 8'h00 || busy !== 1'b1)
         begin bad++; $display("FAIL single_turn: got grant=%b out=%h oe=%h busy=%b want 0000/00/00/1", grant, uio_out, uio_oe, busy); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_round_robin();
      do_reset();
      wr_data = 32'h44332211; wr_oe = 32'hFFFFFFFF;
      req = 4'hF; ena = 1'b1;
      tick();
      for (int r = 0; r < 5; r++) begin
         int idx;
         logic [7:0] exp_out;
         idx = r % 4;
         exp_out = 8'(8'h11 * (idx + 1));
         for (int c = 0; c < 3; c++) begin
            total++; if (grant !== 4'(1 << idx) || uio_out !== exp_out || uio_oe !== 8'hFF)
               begin bad++; $display("FAIL rr_grant r=%0d c=%0d: got grant=%b out=%h oe=%h want %b/%h/ff", r, c, grant, uio_out, uio_oe, 4'(1 << idx), exp_out); end
            if (c < 2) tick();
         end
         req[idx] = 1'b0;
         tick();
         total++; if (grant !== 4'h0 || uio_oe !== 8'h00 || busy !== 1'b1)
            begin bad++; $display("FAIL rr_turn r=%0d: got grant=%b oe=%h busy=%b want 0000/00/1", r, grant, uio_oe, busy); end
         req[idx] = 1'b1;
         tick();
      end
   endtask

   task automatic test_ena();
      do_reset();
      wr_oe = 32'h00FF0000; wr_data = 32'h00C30000;
      ena = 1'b0; req = 4'b0100;
      repeat (3) begin
         tick();
         total++; if (grant !== 4'h0 || uio_oe !== 8'h00 || busy !== 1'b0)
            begin bad++; $display("FAIL ena_off_idle: got grant=%b oe=%h busy=%b want 0000/00/0", grant, uio_oe, busy); end
      end
      ena = 1'b1;
      tick();
      total++; if (grant !== 4'b0100 || uio_oe !== 8'hFF) begin bad++; $display("FAIL ena_on_grant: got grant=%b oe=%h want 0100/ff", grant, uio_oe); end
      ena = 1'b0;
      #1;
      total++; if (uio_oe !== 8'h00) begin bad++; $display("FAIL ena_off_oe: got %h want 00", uio_oe); end
      tick();
      total++; if (grant !== 4'b0100 || busy !== 1'b1) begin bad++; $display("FAIL ena_off_keep: got grant=%b busy=%b want 0100/1", grant, busy); end
      ena = 1'b1;
      #1;
      total++; if (uio_oe !== 8'hFF) begin bad++; $display("FAIL ena_on_oe: got %h want ff", uio_oe); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0001; ena = 1'b1; wr_oe = 32'h000000FF; wr_data = 32'h00000077;
      tick();
      total++; if (uio_oe !== 8'hFF) begin bad++; $display("FAIL rmid_pre: got oe=%h want ff", uio_oe); end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      total++; if (uio_oe !== 8'h00 || grant !== 4'h0 || busy !== 1'b0 || uio_out !== 8'h00)
         begin bad++; $display("FAIL rmid_async: got oe=%h grant=%b busy=%b out=%h want 00/0000/0/00", uio_oe, grant, busy, uio_out); end
      req = 4'b0010;
      tick();
      rst_n = 1'b1;
      tick();
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL rmid_regrant: got %b want 0010", grant); end
      req = 4'b0000;
      tick();
      total++; if (busy !== 1'b1 || grant !== 4'h0) begin bad++; $display("FAIL rmid_turn: got busy=%b grant=%b want 1/0000", busy, grant); end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_turn_abort: got busy=%b want 0", busy); end
      tick();
      rst_n = 1'b1; req = 4'b0101;
      tick();
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rmid_ptr_reset: got %b want 0001", grant); end
   endtask

   task automatic test_timeout();
      do_reset();
      ena = 1'b1; wr_oe = 32'hFFFFFFFF;
`ifdef UIO_ARB_TIMEOUT_EN
      req = 4'b0001;
      tick();
      for (int c = 1; c <= MAX_HOLD; c++) begin
         total++; if (grant !== 4'b0001) begin bad++; $display("FAIL to_hold c=%0d: got %b want 0001", c, grant); end
         if (c == 5) req[2] = 1'b1;
         tick();
      end
      total++; if (grant !== 4'h0 || busy !== 1'b1) begin bad++; $display("FAIL to_turn: got grant=%b busy=%b want 0000/1", grant, busy); end
      tick();
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL to_next: got %b want 0100", grant); end
      req = 4'b0100;
      repeat (40) begin
         tick();
         total++; if (grant !== 4'b0100) begin bad++; $display("FAIL to_alone_keep: got %b want 0100", grant); end
      end
`else
      req = 4'b0101;
      tick();
      repeat (40) begin
         total++; if (grant !== 4'b0001) begin bad++; $display("FAIL no_to_keep: got %b want 0001", grant); end
         tick();
      end
`endif
   endtask

   task automatic test_random();
      logic [3:0] exp_grant;
      logic [7:0] exp_out, exp_oe;
      logic       exp_busy;
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
         ena     = ($urandom_range(0, 9) != 0);
         wr_data = $urandom;
         wr_oe   = $urandom;
         uio_in  = 8'($urandom);
         #1;
         exp_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
         exp_out   = (m_owner >= 0) ? wr_data[8*m_owner +: 8] : 8'h00;
         exp_oe    = (m_owner >= 0 && ena) ? wr_oe[8*m_owner +: 8] : 8'h00;
         exp_busy  = (m_owner >= 0) || (m_turn > 0);
         total++; if (grant !== exp_grant || $countones(grant) > 1)
            begin bad++; $display("FAIL rnd_grant cyc=%0d: got %b want %b", cyc, grant, exp_grant); end
         total++; if (uio_out !== exp_out || uio_oe !== exp_oe)
            begin bad++; $display("FAIL rnd_bus cyc=%0d: got out=%h oe=%h want %h/%h", cyc, uio_out, uio_oe, exp_out, exp_oe); end
         total++; if (busy !== exp_busy || rd_data !== uio_in)
            begin bad++; $display("FAIL rnd_busy_rd cyc=%0d: got busy=%b rd=%h want %b/%h", cyc, busy, rd_data, exp_busy, uio_in); end
         tick();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_ena();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uio_port_arbiter.md
UIO_PORT_ARBITER -- requirements
Module: uio_port_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, setting the hold-cycle limit before preemption (legal range 2..255).
REQ-002 The block SHALL have parameter TURNAROUND, default 1, setting bus-idle cycles between owners (legal range 1..7).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port ena  input  1  arbitration enable.
REQ-006 The block SHALL have port req  input  4  per-requester request level, held high while ownership is wanted.
REQ-007 The block SHALL have port wr_data  input  32  requester n output byte on bits [8n+7:8n].
REQ-008 The block SHALL have port wr_oe  input  32  requester n per-pin output enable on bits [8n+7:8n].
REQ-009 The block SHALL have port uio_in  input  8  pad input byte.
REQ-010 The block SHALL have port uio_out  output  8  pad output byte.
REQ-011 The block SHALL have port uio_oe  output  8  pad output enable, 1 = drive.
REQ-012 The block SHALL have port grant  output  4  registered one-hot owner indication, or all zero.
REQ-013 The block SHALL have port rd_data  output  8  uio_in passed through combinationally to all requesters.
REQ-014 The block SHALL have port busy  output  1  high in GRANT or TURN.

Function
REQ-015 The state machine SHALL have states IDLE, GRANT and TURN.
REQ-016 In IDLE with ena=1 and req!=0, the block SHALL enter GRANT at the next edge, with grant one-hot to the round-robin winner.
REQ-017 Round-robin SHALL search from index (last owner+1) mod 4 upward; after reset the search SHALL start at index 0.
REQ-018 In GRANT, uio_out and uio_oe SHALL equal the owner's wr_data and wr_oe slices (combinational mux from registered grant); outside GRANT both SHALL be 0x00.
REQ-019 In GRANT, owner req low at an edge SHALL move to TURN at that edge with grant cleared.
REQ-020 TURN SHALL last exactly TURNAROUND cycles; at exit, with ena=1 and req!=0, the block SHALL go directly to GRANT for the new winner, otherwise to IDLE.
REQ-021 A hold counter SHALL reset on entry to GRANT, increment each GRANT cycle, and saturate at MAX_HOLD.
REQ-022 Requests from non-owners during GRANT or TURN SHALL remain pending, with no loss and no latching; a req dropped before arbitration SHALL be ignored.
REQ-023 With ena=0, the block SHALL make no new grant (IDLE holds; TURN exit goes to IDLE), force uio_oe=0x00, and keep the current owner and state.
REQ-024 If a requester's req rises at the same edge the owner releases, that requester SHALL be eligible at TURN exit under normal round-robin.
REQ-025 At any time, grant SHALL have at most one bit set.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, grant=0, uio_out=0x00, uio_oe=0x00, busy=0, hold counter=0 and round-robin pointer=0, independent of clk.
REQ-027 Reset assertion mid-GRANT or mid-TURN SHALL abort the transfer; after rst_n release, the first grant SHALL follow REQ-016.

Configuration
REQ-028 With macro UIO_ARB_TIMEOUT_EN defined, an owner in GRANT with hold counter = MAX_HOLD and any other req high SHALL be preempted to TURN at the next edge (grant cleared) and take the lowest round-robin priority.
REQ-029 With UIO_ARB_TIMEOUT_EN defined and no other req high, the owner SHALL keep the bus indefinitely.
REQ-030 Without UIO_ARB_TIMEOUT_EN, there SHALL be no hold counter, no preemption, and ownership SHALL end only on req release or reset.

Verification
REQ-031 Reset, then req=0001, wr_data[7:0]=0xA5, wr_oe[7:0]=0xFF -> grant=0001 one cycle later, uio_out=0xA5, uio_oe=0xFF, busy=1.
REQ-032 req=1111 held, each owner drops req after 3 GRANT cycles, then re-raises -> grant order 0001,0010,0100,1000,0001, with exactly TURNAROUND (1) zero-grant cycles and uio_oe=0x00 between each.
REQ-033 With UIO_ARB_TIMEOUT_EN, req0 held and req2 raised at cycle 5 of GRANT -> grant 0001 ends after 16 GRANT cycles, TURN 1 cycle, then grant=0100.
REQ-034 With ena=0 and req=0100 -> grant stays 0000 and uio_oe=0x00; ena=1 -> grant=0100 next cycle.
REQ-035 rst_n asserted mid-GRANT with uio_oe=0xFF -> uio_oe=0x00 and grant=0000 before the next clk edge; after release with req=0010 -> grant=0010.
